park_gate_ctrl: RTL and testbench
=================================

PARK_GATE_CTRL -- requirements
Module: park_gate_ctrl

Interface
REQ-001 SHALL have parameter PW_DIGITS, default 2, number of password digits.
REQ-002 SHALL have parameter DIGIT_W, default 2, width of each digit in bits.
REQ-003 SHALL have parameter PASSCODE, default 4'b1001 (digit0=01, digit1=10), PW_DIGITS*DIGIT_W bits, correct code.
REQ-004 SHALL have parameter WAIT_CYCLES, default 4, cycles per password entry window (minimum 1).
REQ-005 SHALL have parameter MAX_TRIES, default 3, wrong attempts before lockout.
REQ-006 SHALL have parameter LOCK_CYCLES, default 16, lockout duration in cycles.
REQ-007 SHALL have parameter CAPACITY, default 2, lot capacity; CNT_W = $clog2(CAPACITY+1).
REQ-008 SHALL have parameter BLINK_DIV, default 1, cycles per LED blink toggle.
REQ-009 SHALL have port clk  in  1  clock, rising edge.
REQ-010 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-011 SHALL have port fs  in  1  entry (front) sensor.
REQ-012 SHALL have port bs  in  1  gate-passed (back) sensor.
REQ-013 SHALL have port ex  in  1  one-cycle car-left-lot pulse.
REQ-014 SHALL have port pw  in  PW_DIGITS*DIGIT_W  password; digit i = pw[i*DIGIT_W +: DIGIT_W].
REQ-015 SHALL have ports green_led and red_led  out  1 each  status LEDs.
REQ-016 SHALL have ports hex_1 and hex_2  out  7 each  active-low 7-segment display codes.
REQ-017 SHALL have port occupancy  out  CNT_W  cars in lot.
REQ-018 SHALL have ports full and locked  out  1 each  status flags.

Function
REQ-019 SHALL implement states IDLE, WAIT_PW, WRONG_PW, RIGHT_PW, STOP, LOCKOUT.
REQ-020 IDLE: fs=1 with occupancy<CAPACITY SHALL go to WAIT_PW; fs=1 with occupancy==CAPACITY SHALL stay in IDLE.
REQ-021 In WAIT_PW, WRONG_PW and STOP, a window timer SHALL count from 0; at count WAIT_CYCLES-1, pw SHALL be compared with PASSCODE and the timer SHALL reload to 0.
REQ-022 A match SHALL go to RIGHT_PW and clear the try counter.
REQ-023 A mismatch SHALL increment the try counter; if the incremented value equals MAX_TRIES, the block SHALL go to LOCKOUT, else to WRONG_PW (from STOP: stay in STOP).
REQ-024 LOCKOUT SHALL last exactly LOCK_CYCLES cycles, then go to IDLE with the try counter cleared; all inputs except ex SHALL be ignored.
REQ-025 RIGHT_PW: bs=1 and fs=1 SHALL go to STOP; bs=1 alone SHALL go to IDLE and increment occupancy; otherwise stay.
REQ-026 ex=1 SHALL decrement occupancy, saturating at 0, in every state.
REQ-027 A same-cycle increment and ex SHALL leave occupancy unchanged.
REQ-028 Occupancy SHALL never exceed CAPACITY.
REQ-029 full SHALL be registered as (occupancy==CAPACITY); locked SHALL be high exactly while the state is LOCKOUT.
REQ-030 LED and hex outputs SHALL be registered from the current state, lagging it by one cycle.
REQ-031 Output map (green, red, hex_1, hex_2) SHALL be:
- IDLE: 0, 0, 1111111, 1111111.
- IDLE with full=1: 0, 1, 0001110 "F", 1000111 "L".
- WAIT_PW: 0, 1, 0000110 "E", 0101011 "n".
- WRONG_PW: 0, blink, "E", "E".
- RIGHT_PW: blink, 0, 0000010 "6", 1000000 "0".
- STOP: 0, blink, 0010010 "5", 0001100 "P".
- LOCKOUT: 0, 1, "L", "0".
REQ-032 Blink SHALL toggle every BLINK_DIV cycles and SHALL restart from 0 on entry to any state.

Reset
REQ-033 rst=0 SHALL immediately force the following, including mid-operation:
- state IDLE; timers and try counter 0.
- occupancy 0; full 0; locked 0.
- both LEDs 0; hex_1 and hex_2 1111111.

Verification
REQ-034 Defaults, reset released, fs=1 for 1 cycle, pw=4'b1001 -> WAIT_PW for 4 cycles, then RIGHT_PW; hex "6","0"; green toggles each cycle.
REQ-035 From RIGHT_PW, bs=1 -> IDLE, occupancy 0->1; repeat -> occupancy 2, full=1; then fs=1 -> stays IDLE, red=1, hex "F","L".
REQ-036 pw=4'b0000 held -> WRONG_PW after 4 cycles, second attempt 4 cycles later, LOCKOUT after the third; locked=1 for 16 cycles; fs is ignored; then IDLE.
REQ-037 In RIGHT_PW, fs=1 and bs=1 together -> STOP ("5","P", red blinking); pw=4'b1001 -> RIGHT_PW after 4 cycles.
REQ-038 Occupancy=1 with bs=1 in RIGHT_PW and ex=1 in the same cycle -> occupancy stays 1; ex=1 at occupancy 0 -> stays 0.
REQ-039 rst=0 asserted in WRONG_PW after 1 wrong try -> all outputs at reset values immediately; a later correct entry shows no stale try count.

Source files
------------

// File: rtl/park_gate_ctrl.sv
// Parking lot entry gate: password entry with retry lockout, occupancy
// tracking and registered LED / 7-segment status outputs.
module park_gate_ctrl #(
    parameter int PW_DIGITS   = 2,
    parameter int DIGIT_W     = 2,
    parameter logic [PW_DIGITS*DIGIT_W-1:0] PASSCODE = 4'b1001,
    parameter int WAIT_CYCLES = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int CAPACITY    = 2,
    localparam int CNT_W      = $clog2(CAPACITY + 1),
    parameter int BLINK_DIV   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fs,
    input  logic                           bs,
    input  logic                           ex,
    input  logic [PW_DIGITS*DIGIT_W-1:0]   pw,
    output logic                           green_led,
    output logic                           red_led,
    output logic [6:0]                     hex_1,
    output logic [6:0]                     hex_2,
    output logic [CNT_W-1:0]               occupancy,
    output logic                           full,
    output logic                           locked
);

    localparam int TW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int LW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TRW = $clog2(MAX_TRIES + 1);

    localparam logic [TW-1:0]    TMR_END   = TW'(WAIT_CYCLES - 1);
    localparam logic [LW-1:0]    LOCK_END  = LW'(LOCK_CYCLES - 1);
    localparam logic [BW-1:0]    BLINK_END = BW'(BLINK_DIV - 1);
    localparam logic [TRW-1:0]   TRIES_MAX = TRW'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PW,
        WRONG_PW,
        RIGHT_PW,
        STOP,
        LOCKOUT
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [LW-1:0]     lockCnt_q, lockCnt_d;
    logic [TRW-1:0]    tries_q, tries_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [BW-1:0]     blinkCnt_q, blinkCnt_d;
    logic              blink_q, blink_d;
    logic              full_q;
    logic              green_q, green_d;
    logic              red_q, red_d;
    logic [6:0]        hex1_q, hex1_d;
    logic [6:0]        hex2_q, hex2_d;
    logic              carIn;
    logic              windowEnd;

    // Next state: the window timer only runs in states that wait for a code.
    always_comb begin
        state_d   = state_q;
        tmr_d     = '0;
        lockCnt_d = '0;
        tries_d   = tries_q;
        carIn     = 1'b0;
        windowEnd = (tmr_q == TMR_END);
        case (state_q)
            IDLE: begin
                if (fs && (occ_q < CAP_V)) state_d = WAIT_PW;
            end
            WAIT_PW, WRONG_PW, STOP: begin
                tmr_d = windowEnd ? '0 : tmr_q + 1'b1;
                if (windowEnd) begin
                    if (pw == PASSCODE) begin
                        state_d = RIGHT_PW;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_q + 1'b1;
                        if (tries_d == TRIES_MAX) state_d = LOCKOUT;
                        else if (state_q != STOP) state_d = WRONG_PW;
                    end
                end
            end
            RIGHT_PW: begin
                if (bs && fs) begin
                    state_d = STOP;
                end else if (bs) begin
                    state_d = IDLE;
                    carIn   = 1'b1;
                end
            end
            LOCKOUT: begin
                if (lockCnt_q == LOCK_END) begin
                    state_d = IDLE;
                    tries_d = '0;
                end else begin
                    lockCnt_d = lockCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A car entering and a car leaving in the same cycle cancel out.
    always_comb begin
        occ_d = occ_q;
        if (carIn && !ex) begin
            if (occ_q != CAP_V) occ_d = occ_q + 1'b1;
        end else if (ex && !carIn) begin
            if (occ_q != '0) occ_d = occ_q - 1'b1;
        end
    end

    always_comb begin
        blinkCnt_d = blinkCnt_q + 1'b1;
        blink_d    = blink_q;
        if (state_d != state_q) begin
            blinkCnt_d = '0;
            blink_d    = 1'b0;
        end else if (blinkCnt_q == BLINK_END) begin
            blinkCnt_d = '0;
            blink_d    = ~blink_q;
        end
    end

    always_comb begin
        green_d = 1'b0;
        red_d   = 1'b0;
        hex1_d  = SEG_BLANK;
        hex2_d  = SEG_BLANK;
        case (state_q)
            IDLE: begin
                if (full_q) begin
                    red_d  = 1'b1;
                    hex1_d = SEG_F;
                    hex2_d = SEG_L;
                end
            end
            WAIT_PW: begin
                red_d  = 1'b1;
                hex1_d = SEG_E;
                hex2_d = SEG_N;
            end
            WRONG_PW: begin
                red_d  = blink_q;
                hex1_d = SEG_E;
                hex2_d = SEG_E;
            end
            RIGHT_PW: begin
                green_d = blink_q;
                hex1_d  = SEG_6;
                hex2_d  = SEG_0;
            end
            STOP: begin
                red_d  = blink_q;
                hex1_d = SEG_5;
                hex2_d = SEG_P;
            end
            LOCKOUT: begin
                red_d  = 1'b1;
                hex1_d = SEG_L;
                hex2_d = SEG_0;
            end
            default: begin
                red_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            lockCnt_q  <= '0;
            tries_q    <= '0;
            occ_q      <= '0;
            blinkCnt_q <= '0;
            blink_q    <= 1'b0;
            full_q     <= 1'b0;
            green_q    <= 1'b0;
            red_q      <= 1'b0;
            hex1_q     <= SEG_BLANK;
            hex2_q     <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            lockCnt_q  <= lockCnt_d;
            tries_q    <= tries_d;
            occ_q      <= occ_d;
            blinkCnt_q <= blinkCnt_d;
            blink_q    <= blink_d;
            full_q     <= (occ_d == CAP_V);
            green_q    <= green_d;
            red_q      <= red_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
        end
    end

    assign green_led = green_q;
    assign red_led   = red_q;
    assign hex_1     = hex1_q;
    assign hex_2     = hex2_q;
    assign occupancy = occ_q;
    assign full      = full_q;
    assign locked    = (state_q == LOCKOUT);

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Bench for park_gate_ctrl: a cycle model tracks phase and time-in-phase,
// and directed scenarios pin literal values along the way.
module tb_park_gate_ctrl;

    localparam int CAPACITY    = 2;
    localparam int WAIT_CYCLES = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int BLINK_DIV   = 1;
    localparam logic [3:0] PASS = 4'b1001;

    localparam logic [6:0] H_BLANK = 7'b1111111;
    localparam logic [6:0] H_F     = 7'b0001110;
    localparam logic [6:0] H_L     = 7'b1000111;
    localparam logic [6:0] H_E     = 7'b0000110;
    localparam logic [6:0] H_N     = 7'b0101011;
    localparam logic [6:0] H_6     = 7'b0000010;
    localparam logic [6:0] H_0     = 7'b1000000;
    localparam logic [6:0] H_5     = 7'b0010010;
    localparam logic [6:0] H_P     = 7'b0001100;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_WRONG = 2;
    localparam int P_RIGHT = 3;
    localparam int P_STOP  = 4;
    localparam int P_LOCK  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fs  = 1'b0;
    logic       bs  = 1'b0;
    logic       ex  = 1'b0;
    logic [3:0] pw  = 4'b0000;
    logic       green_led, red_led, full, locked;
    logic [6:0] hex_1, hex_2;
    logic [1:0] occupancy;

    int vectors     = 0;
    int miscompares = 0;

    park_gate_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .fs        (fs),
        .bs        (bs),
        .ex        (ex),
        .pw        (pw),
        .green_led (green_led),
        .red_led   (red_led),
        .hex_1     (hex_1),
        .hex_2     (hex_2),
        .occupancy (occupancy),
        .full      (full),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int         mPhase = P_IDLE;
    int         mAge   = 0;
    int         mTries = 0;
    int         mOcc   = 0;
    int         mNext  = P_IDLE;
    bit         mCarIn = 1'b0;
    logic [15:0] eShow = {2'b00, H_BLANK, H_BLANK};

    // What the lamps and digits show for a phase, given time spent in it.
    function automatic logic [15:0] showFor(int phase, int age, bit isFull);
        bit blink;
        blink = ((age / BLINK_DIV) % 2) == 1;
        case (phase)
            P_IDLE:  return isFull ? {1'b0, 1'b1, H_F, H_L} : {2'b00, H_BLANK, H_BLANK};
            P_WAIT:  return {1'b0, 1'b1, H_E, H_N};
            P_WRONG: return {1'b0, blink, H_E, H_E};
            P_RIGHT: return {blink, 1'b0, H_6, H_0};
            P_STOP:  return {1'b0, blink, H_5, H_P};
            default: return {1'b0, 1'b1, H_L, H_0};
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPhase = P_IDLE;
            mAge   = 0;
            mTries = 0;
            mOcc   = 0;
            eShow  = {2'b00, H_BLANK, H_BLANK};
        end else begin
            eShow  = showFor(mPhase, mAge, mOcc == CAPACITY);
            mNext  = mPhase;
            mCarIn = 1'b0;
            case (mPhase)
                P_IDLE: if (fs && mOcc < CAPACITY) mNext = P_WAIT;
                P_WAIT, P_WRONG, P_STOP: begin
                    if (mAge % WAIT_CYCLES == WAIT_CYCLES - 1) begin
                        if (pw == PASS) begin
                            mNext  = P_RIGHT;
                            mTries = 0;
                        end else begin
                            mTries = mTries + 1;
                            if (mTries == MAX_TRIES) mNext = P_LOCK;
                            else if (mPhase != P_STOP) mNext = P_WRONG;
                        end
                    end
                end
                P_RIGHT: begin
                    if (bs && fs) mNext = P_STOP;
                    else if (bs) begin
                        mNext  = P_IDLE;
                        mCarIn = 1'b1;
                    end
                end
                default: begin
                    if (mAge == LOCK_CYCLES - 1) begin
                        mNext  = P_IDLE;
                        mTries = 0;
                    end
                end
            endcase
            if (mCarIn && !ex) mOcc = (mOcc < CAPACITY) ? mOcc + 1 : mOcc;
            else if (ex && !mCarIn) mOcc = (mOcc > 0) ? mOcc - 1 : 0;
            mAge   = (mNext != mPhase) ? 0 : mAge + 1;
            mPhase = mNext;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("model green", {31'd0, green_led}, {31'd0, eShow[15]});
            checkOutput("model red", {31'd0, red_led}, {31'd0, eShow[14]});
            checkOutput("model hex_1", {25'd0, hex_1}, {25'd0, eShow[13:7]});
            checkOutput("model hex_2", {25'd0, hex_2}, {25'd0, eShow[6:0]});
            checkOutput("model occupancy", {30'd0, occupancy}, mOcc);
            checkOutput("model full", {31'd0, full}, {31'd0, mOcc == CAPACITY});
            checkOutput("model locked", {31'd0, locked}, {31'd0, mPhase == P_LOCK});
        end
    end

    task automatic applyStimulus(input logic fsV, input logic bsV, input logic exV,
                                 input logic [3:0] pwV, input int cycles);
        fs = fsV;
        bs = bsV;
        ex = exV;
        pw = pwV;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic enterRight();
        applyStimulus(1'b1, 1'b0, 1'b0, PASS, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, PASS, WAIT_CYCLES);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " green"}, {31'd0, green_led}, 32'd0);
        checkOutput({tag, " red"}, {31'd0, red_led}, 32'd0);
        checkOutput({tag, " hex_1"}, {25'd0, hex_1}, 32'h7f);
        checkOutput({tag, " hex_2"}, {25'd0, hex_2}, 32'h7f);
        checkOutput({tag, " occupancy"}, {30'd0, occupancy}, 32'd0);
        checkOutput({tag, " full"}, {31'd0, full}, 32'd0);
        checkOutput({tag, " locked"}, {31'd0, locked}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;

        // Correct code: four cycles of entry window, then the gate opens.
        applyStimulus(1'b1, 1'b0, 1'b0, PASS, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, PASS, 1);
        checkOutput("wait hex_1", {25'd0, hex_1}, 32'h06);
        checkOutput("wait hex_2", {25'd0, hex_2}, 32'h2b);
        checkOutput("wait red", {31'd0, red_led}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, PASS, 3);
        checkOutput("still wait hex_1", {25'd0, hex_1}, 32'h06);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("right hex_1", {25'd0, hex_1}, 32'h02);
        checkOutput("right hex_2", {25'd0, hex_2}, 32'h40);
        checkOutput("right green phase0", {31'd0, green_led}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("right green phase1", {31'd0, green_led}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("right green phase2", {31'd0, green_led}, 32'd0);

        // Two cars in fill the lot; a third is turned away.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1);
        checkOutput("first car occupancy", {30'd0, occupancy}, 32'd1);
        checkOutput("first car full", {31'd0, full}, 32'd0);
        enterRight();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1);
        checkOutput("second car occupancy", {30'd0, occupancy}, 32'd2);
        checkOutput("second car full", {31'd0, full}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, PASS, 1);
        checkOutput("full red", {31'd0, red_led}, 32'd1);
        checkOutput("full hex_1", {25'd0, hex_1}, 32'h0e);
        checkOutput("full hex_2", {25'd0, hex_2}, 32'h47);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("full stays idle", {25'd0, hex_1}, 32'h0e);

        // Departures, simultaneous in/out, and floor at zero.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1);
        checkOutput("exit occupancy", {30'd0, occupancy}, 32'd1);
        checkOutput("exit full", {31'd0, full}, 32'd0);
        enterRight();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 1);
        checkOutput("in and out occupancy", {30'd0, occupancy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1);
        checkOutput("exit at zero", {30'd0, occupancy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);

        // Tailgating car stops the gate until the code is re-entered.
        enterRight();
        applyStimulus(1'b1, 1'b1, 1'b0, PASS, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, PASS, 1);
        checkOutput("stop hex_1", {25'd0, hex_1}, 32'h12);
        checkOutput("stop hex_2", {25'd0, hex_2}, 32'h0c);
        checkOutput("stop red phase0", {31'd0, red_led}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, PASS, 1);
        checkOutput("stop red phase1", {31'd0, red_led}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, PASS, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("stop to right hex_1", {25'd0, hex_1}, 32'h02);
        checkOutput("stop no car occupancy", {30'd0, occupancy}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1);

        // Three wrong codes lock the gate for sixteen cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 5);
        checkOutput("wrong hex_2", {25'd0, hex_2}, 32'h06);
        checkOutput("wrong red phase0", {31'd0, red_led}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 7);
        checkOutput("lockout entered", {31'd0, locked}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, PASS, LOCK_CYCLES - 1);
        checkOutput("lockout last cycle", {31'd0, locked}, 32'd1);
        checkOutput("lockout hex_1", {25'd0, hex_1}, 32'h47);
        checkOutput("lockout hex_2", {25'd0, hex_2}, 32'h40);
        checkOutput("lockout occupancy", {30'd0, occupancy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("lockout released", {31'd0, locked}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("after lockout hex_1", {25'd0, hex_1}, 32'h7f);

        // Reset in the middle of a wrong-code window wipes everything.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 6);
        #2 rst = 1'b0;
        #1 checkResetValues("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8);
        checkOutput("no stale tries", {31'd0, locked}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, PASS, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
        checkOutput("post reset right hex_1", {25'd0, hex_1}, 32'h02);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
